// File: rtl/mpsoc_uart_apb_host.sv
// rtl/mpsoc_uart_apb_host.sv - APB3 initiator that initialises a 16550-style UART and moves bytes to/from streams
// Optional build macro: MPSOC_UART_HOST_IRQ_EN (adds irq_i, interrupt-driven polling, IER=0x03)
module mpsoc_uart_apb_host #(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter int          APB_DATA_WIDTH = 32,
    parameter int          UART_BASE      = 0,
    parameter logic [15:0] DIVISOR        = 16'd27,
    parameter logic [7:0]  LCR_CFG        = 8'h03,
    parameter logic [7:0]  FCR_CFG        = 8'h06,
    parameter int          TX_BURST       = 16,
    parameter int          POLL_GAP       = 4
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
`ifdef MPSOC_UART_HOST_IRQ_EN
    input  logic                      irq_i,
`endif
    input  logic [7:0]                tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic [7:0]                rx_data_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output logic                      rx_perr_o,
    output logic                      init_done_o,
    output logic                      err_o
);

    localparam logic [2:0] REG_RBR_THR = 3'd0;
    localparam logic [2:0] REG_IER_DLM = 3'd1;
    localparam logic [2:0] REG_IIR_FCR = 3'd2;
    localparam logic [2:0] REG_LCR     = 3'd3;
    localparam logic [2:0] REG_LSR     = 3'd5;
`ifdef MPSOC_UART_HOST_IRQ_EN
    localparam logic [7:0] IER_CFG     = 8'h03;
`else
    localparam logic [7:0] IER_CFG     = 8'h00;
`endif

    typedef enum logic [3:0] {
        INIT0, INIT1, INIT2, INIT3, INIT4, INIT5,
        POLL, DECIDE, RXRD, TXWR,
`ifdef MPSOC_UART_HOST_IRQ_EN
        IIRRD, WAIT_IRQ
`else
        GAP
`endif
    } state_t;

    state_t     state, state_nxt;
    logic       tx_full;
    logic [7:0] tx_hold;
    logic       lsr_dr, lsr_pe, lsr_thre;
    logic [4:0] burst_cnt;
    logic       xfer_done, tx_load, launch, is_xfer, set_write;
    logic [2:0] set_addr;
    logic [7:0] set_byte;
    logic       unused_prdata;
`ifndef MPSOC_UART_HOST_IRQ_EN
    logic [7:0] gap_cnt;
`endif

    assign xfer_done     = PSEL & PENABLE & PREADY;
    assign tx_ready_o    = init_done_o & ~tx_full;
    assign tx_load       = tx_valid_i & tx_ready_o;
    assign unused_prdata = ^PRDATA[APB_DATA_WIDTH-1:8];

    always_comb begin
        state_nxt = state;
        case (state)
            INIT0:  if (xfer_done) state_nxt = INIT1;
            INIT1:  if (xfer_done) state_nxt = INIT2;
            INIT2:  if (xfer_done) state_nxt = INIT3;
            INIT3:  if (xfer_done) state_nxt = INIT4;
            INIT4:  if (xfer_done) state_nxt = INIT5;
            INIT5:  if (xfer_done) state_nxt = POLL;
            POLL:   if (xfer_done) state_nxt = DECIDE;
            DECIDE: begin
                if (lsr_dr && !rx_valid_o)
                    state_nxt = RXRD;
                else if (lsr_thre && tx_full)
                    state_nxt = TXWR;
                else
`ifdef MPSOC_UART_HOST_IRQ_EN
                    state_nxt = WAIT_IRQ;
`else
                    state_nxt = GAP;
`endif
            end
            RXRD:   if (xfer_done) state_nxt = POLL;
            // PSEL low inside TXWR marks the one-cycle refill window after a THR write
            TXWR:   if (!PSEL) state_nxt = (tx_load && int'(burst_cnt) < TX_BURST) ? TXWR : POLL;
`ifdef MPSOC_UART_HOST_IRQ_EN
            IIRRD:  if (xfer_done) state_nxt = POLL;
            WAIT_IRQ: begin
                if (irq_i)
                    state_nxt = IIRRD;
                else if (tx_full && lsr_thre)
                    state_nxt = POLL;
            end
`else
            GAP:    if (tx_full || int'(gap_cnt) == POLL_GAP - 1) state_nxt = POLL;
`endif
            default: state_nxt = INIT0;
        endcase
    end

    // Address/data of the transfer that state_nxt will perform, and whether it starts now
    always_comb begin
        set_addr  = REG_RBR_THR;
        set_byte  = 8'h00;
        set_write = 1'b0;
        is_xfer   = 1'b1;
        case (state_nxt)
            INIT0: begin set_addr = REG_LCR;     set_byte = 8'h80 | LCR_CFG; set_write = 1'b1; end
            INIT1: begin set_addr = REG_RBR_THR; set_byte = DIVISOR[7:0];    set_write = 1'b1; end
            INIT2: begin set_addr = REG_IER_DLM; set_byte = DIVISOR[15:8];   set_write = 1'b1; end
            INIT3: begin set_addr = REG_LCR;     set_byte = LCR_CFG;         set_write = 1'b1; end
            INIT4: begin set_addr = REG_IIR_FCR; set_byte = FCR_CFG;         set_write = 1'b1; end
            INIT5: begin set_addr = REG_IER_DLM; set_byte = IER_CFG;         set_write = 1'b1; end
            POLL:  set_addr = REG_LSR;
            RXRD:  set_addr = REG_RBR_THR;
            TXWR: begin
                set_addr  = REG_RBR_THR;
                set_byte  = tx_load ? tx_data_i : tx_hold;
                set_write = 1'b1;
            end
`ifdef MPSOC_UART_HOST_IRQ_EN
            IIRRD: set_addr = REG_IIR_FCR;
`endif
            default: is_xfer = 1'b0;
        endcase
        launch = is_xfer && (!PSEL || (xfer_done && state != TXWR));
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= INIT0;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else if (launch) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= set_write;
            PADDR   <= APB_ADDR_WIDTH'(UART_BASE + int'(set_addr));
            PWDATA  <= APB_DATA_WIDTH'(set_byte);
        end else if (PSEL && !PENABLE) begin
            PENABLE <= 1'b1;
        end else if (xfer_done) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tx_full     <= 1'b0;
            tx_hold     <= 8'h00;
            lsr_dr      <= 1'b0;
            lsr_pe      <= 1'b0;
            lsr_thre    <= 1'b0;
            rx_data_o   <= 8'h00;
            rx_valid_o  <= 1'b0;
            rx_perr_o   <= 1'b0;
            init_done_o <= 1'b0;
            err_o       <= 1'b0;
            burst_cnt   <= 5'd0;
        end else begin
            if (tx_load) begin
                tx_full <= 1'b1;
                tx_hold <= tx_data_i;
            end else if (xfer_done && state == TXWR) begin
                tx_full <= 1'b0;
            end

            if (xfer_done && state == POLL) begin
                lsr_dr   <= PRDATA[0];
                lsr_pe   <= PRDATA[2];
                lsr_thre <= PRDATA[5];
            end

            if (xfer_done && state == RXRD) begin
                rx_data_o  <= PRDATA[7:0];
                rx_valid_o <= 1'b1;
                rx_perr_o  <= lsr_pe;
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            if (xfer_done && state == INIT5)
                init_done_o <= 1'b1;
            if (xfer_done && PSLVERR)
                err_o <= 1'b1;

            if (state_nxt == POLL && state != POLL)
                burst_cnt <= 5'd0;
            else if (xfer_done && state == TXWR)
                burst_cnt <= burst_cnt + 5'd1;
        end
    end

`ifndef MPSOC_UART_HOST_IRQ_EN
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            gap_cnt <= 8'd0;
        else if (state == GAP)
            gap_cnt <= gap_cnt + 8'd1;
        else
            gap_cnt <= 8'd0;
    end
`endif

endmodule

// File: tb/tb_mpsoc_uart_apb_host.sv
// tb/tb_mpsoc_uart_apb_host.sv - directed bench for mpsoc_uart_apb_host with a small APB UART slave model
module tb_mpsoc_uart_apb_host;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [7:0]  tx_data_i = 8'h00;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o, rx_perr_o, init_done_o, err_o;
    logic        rx_ready_i = 1'b0;

    logic [7:0]  lsr_val = 8'h00;
    logic [7:0]  rbr_val = 8'h00;
    logic        wait_armed = 1'b0;
    logic        armed_done = 1'b0;
    logic [1:0]  acc_cnt = 2'd0;
    logic        hit;

    int          cyc = 0, acc = 0, stab_bad = 0, armed_acc = 0, rbr_reads = 0, done_cyc = 0;
    logic [11:0] s_addr = 12'h0;
    logic [31:0] s_data = 32'h0;
    logic        s_wr = 1'b0;
    logic [15:0] wr_log[$];
    logic [7:0]  ev_log[$];
    int          n_tests = 0, n_fail = 0;

    logic [15:0] exp_init [6] = '{16'h0383, 16'h001B, 16'h0100, 16'h0303, 16'h0206, 16'h0100};

    always #5 CLK = ~CLK;

    mpsoc_uart_apb_host dut (
        .CLK(CLK), .RSTN(RSTN),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .rx_perr_o(rx_perr_o), .init_done_o(init_done_o), .err_o(err_o)
    );

    // Slave: 3 wait states plus PSLVERR on the first register-1 write once armed (the DLM write)
    assign hit     = wait_armed && !armed_done && PSEL && PENABLE && PWRITE && PADDR == 12'h001;
    assign PREADY  = !hit || acc_cnt == 2'd3;
    assign PSLVERR = hit;
    assign PRDATA  = (PADDR == 12'h005) ? {24'h0, lsr_val} :
                     (PADDR == 12'h000) ? {24'h0, rbr_val} : 32'h0;

    always @(posedge CLK) begin
        acc_cnt <= (hit && !PREADY) ? acc_cnt + 2'd1 : 2'd0;
        if (!wait_armed)
            armed_done <= 1'b0;
        else if (hit && PREADY)
            armed_done <= 1'b1;
    end

    always @(posedge CLK) begin
        if (PSEL && PENABLE) begin
            acc++;
            if (PADDR !== s_addr || PWDATA !== s_data || PWRITE !== s_wr)
                stab_bad++;
            if (PREADY) begin
                done_cyc = cyc;
                if (hit)
                    armed_acc = acc;
                if (PWRITE)
                    wr_log.push_back({PADDR[7:0], PWDATA[7:0]});
                else if (PADDR == 12'h000)
                    rbr_reads++;
                ev_log.push_back(PWRITE ? 8'h57 : PADDR[7:0]);
            end
        end else if (PSEL) begin
            s_addr = PADDR;
            s_data = PWDATA;
            s_wr   = PWRITE;
            acc    = 0;
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done_o && n < 300) begin @(negedge CLK); n++; end
        check(tag, 32'(init_done_o), 1);
    endtask

    task automatic wait_rx(input string tag);
        int n = 0;
        while (!rx_valid_o && n < 200) begin @(negedge CLK); n++; end
        check(tag, 32'(rx_valid_o), 1);
    endtask

    task automatic wait_thr(input string tag);
        int n = 0;
        while (!(PSEL && PENABLE && PWRITE && PADDR == 12'h000) && n < 200) begin @(negedge CLK); n++; end
        check(tag, 32'(PSEL && PENABLE && PWRITE && PADDR == 12'h000), 1);
    endtask

    initial begin
        int base, wbase, rbase, first_w, n_w, ok, late;

        @(negedge CLK);
        check("rst_psel_penable", {30'b0, PSEL, PENABLE}, 0);
        check("rst_paddr", 32'(PADDR), 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_flags", {26'b0, PWRITE, tx_ready_o, rx_valid_o, rx_perr_o, init_done_o, err_o}, 0);
        check("rst_rx_data", 32'(rx_data_o), 0);

        @(negedge CLK);
        RSTN = 1'b1;
        wait_init("init_wait");
        check("init_done_latency", cyc, done_cyc + 1);
        check("init_nwrites", wr_log.size(), 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("init_wr%0d", k), 32'(wr_log[k]), 32'(exp_init[k]));
        check("init_err", 32'(err_o), 0);

        lsr_val = 8'h60;
        base = wr_log.size();
        check("tx_ready_idle", 32'(tx_ready_o), 1);
        tx_data_i  = 8'h55;
        tx_valid_i = 1'b1;
        @(negedge CLK);
        tx_valid_i = 1'b0;
        check("tx_ready_drop", 32'(tx_ready_o), 0);
        wait_thr("tx_thr_wait");
        check("tx_ready_at_done", 32'(tx_ready_o), 0);
        @(negedge CLK);
        check("tx_ready_back", 32'(tx_ready_o), 1);
        repeat (30) @(negedge CLK);
        check("tx_one_write", wr_log.size() - base, 1);
        check("tx_write_val", 32'(wr_log[base]), 32'h0055);

        lsr_val = 8'h01;
        rbr_val = 8'hA5;
        rbase   = rbr_reads;
        wait_rx("rx1_wait");
        check("rx1_data", 32'(rx_data_o), 32'hA5);
        check("rx1_perr", 32'(rx_perr_o), 0);
        repeat (40) @(negedge CLK);
        check("rx_backpressure_reads", rbr_reads - rbase, 1);
        check("rx1_held", {23'b0, rx_valid_o, rx_data_o}, 32'h1A5);
        lsr_val = 8'h05;
        rbr_val = 8'h3C;
        repeat (12) @(negedge CLK);
        rx_ready_i = 1'b1;
        @(negedge CLK);
        rx_ready_i = 1'b0;
        check("rx_valid_cleared", 32'(rx_valid_o), 0);
        wait_rx("rx2_wait");
        check("rx2_data", 32'(rx_data_o), 32'h3C);
        check("rx2_perr", 32'(rx_perr_o), 1);
        check("rx2_reads", rbr_reads - rbase, 2);
        lsr_val = 8'h00;
        repeat (12) @(negedge CLK);
        rx_ready_i = 1'b1;
        @(negedge CLK);
        rx_ready_i = 1'b0;

        lsr_val = 8'h60;
        base  = ev_log.size();
        wbase = wr_log.size();
        late  = 0;
        for (int i = 0; i < 20; i++) begin
            int n = 0;
            tx_data_i  = 8'h10 + 8'(i);
            tx_valid_i = 1'b1;
            while (!tx_ready_o && n < 200) begin @(negedge CLK); n++; end
            if (!tx_ready_o) late++;
            @(negedge CLK);
        end
        tx_valid_i = 1'b0;
        check("burst_ready_timeouts", late, 0);
        repeat (60) @(negedge CLK);
        first_w = -1;
        n_w = 0;
        for (int k = base; k < ev_log.size(); k++) begin
            if (ev_log[k] == 8'h57) begin
                n_w++;
                if (first_w < 0) first_w = k;
            end
        end
        if (first_w < 0) first_w = base;
        check("burst_nwrites", n_w, 20);
        ok = 1;
        for (int k = 0; k < 16; k++)
            if (ev_log[first_w + k] != 8'h57) ok = 0;
        check("burst_first16", ok, 1);
        check("burst_mid_poll", 32'(ev_log[first_w + 16]), 32'h05);
        ok = 1;
        for (int k = 17; k < 21; k++)
            if (ev_log[first_w + k] != 8'h57) ok = 0;
        check("burst_last4", ok, 1);
        ok = 1;
        for (int i = 0; i < 20; i++)
            if (wr_log[wbase + i] != {8'h00, 8'h10 + 8'(i)}) ok = 0;
        check("burst_data", ok, 1);

        RSTN       = 1'b0;
        wait_armed = 1'b1;
        lsr_val    = 8'h00;
        @(negedge CLK);
        check("rst2_state", {29'b0, init_done_o, err_o, PSEL}, 0);
        wbase = wr_log.size();
        RSTN  = 1'b1;
        wait_init("err_init_wait");
        check("err_access_cycles", armed_acc, 4);
        check("err_set", 32'(err_o), 1);
        check("err_init_nwrites", wr_log.size() - wbase, 6);
        check("err_dlm_write", 32'(wr_log[wbase + 2]), 32'h0100);
        check("err_ier_write", 32'(wr_log[wbase + 5]), 32'h0100);
        repeat (20) @(negedge CLK);
        check("err_sticky", 32'(err_o), 1);
        check("apb_stability", stab_bad, 0);
        wait_armed = 1'b0;

        lsr_val    = 8'h60;
        tx_data_i  = 8'hC3;
        tx_valid_i = 1'b1;
        begin
            int n = 0;
            while (!tx_ready_o && n < 200) begin @(negedge CLK); n++; end
        end
        @(negedge CLK);
        tx_valid_i = 1'b0;
        wait_thr("abort_thr_wait");
        RSTN = 1'b0;
        #1;
        check("abort_psel_penable", {30'b0, PSEL, PENABLE}, 0);
        wbase = wr_log.size();
        @(negedge CLK);
        RSTN = 1'b1;
        wait_init("abort_init_wait");
        check("abort_restart_first", 32'(wr_log[wbase]), 32'h0383);
        check("abort_restart_nwrites", wr_log.size() - wbase, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
